// File: rtl/seq_mul_feeder.sv
// Transmit-side controller for a bit-serial sequential multiplier: accepts Q/M,
// clears the multiplier, streams M out LSB first, then captures and presents the product.
module seq_mul_feeder #(
   parameter int WIDTH = 8,
   parameter int LAT   = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     q_in,
   input  logic [WIDTH-1:0]     m_in,
   output logic [WIDTH-1:0]     mul_q,
   output logic                 mul_clr,
   output logic                 mul_frame,
   output logic                 mul_bit,
   input  logic [2*WIDTH-1:0]   mul_prod,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod
);

   // state  | meaning
   // IDLE   | waiting for an operand pair
   // CLR    | one-clock clear pulse to the multiplier
   // SHIFT  | WIDTH clocks of framed serial bits, LSB first
   // WAIT   | LAT clocks of multiplier latency, product sampled on the last
   // RESP   | product held on the result port until the handshake
   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_SHIFT,
      S_WAIT,
      S_RESP
   } state_t;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t            r_state;
   state_t            w_next;
   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  r_shreg;
   logic [CW-1:0]     r_bit_cnt;
   logic [3:0]        r_wait_cnt;
   logic [2*WIDTH-1:0] r_prod;

   logic w_accept;
   logic w_shift_last;
   logic w_wait_last;

   assign w_accept     = (r_state == S_IDLE) && in_valid;
   assign w_shift_last = (r_bit_cnt == CW'(WIDTH - 1));
   assign w_wait_last  = (r_wait_cnt == 4'(LAT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid) w_next = S_CLR;
         S_CLR:   w_next = S_SHIFT;
         S_SHIFT: if (w_shift_last) w_next = S_WAIT;
         S_WAIT:  if (w_wait_last) w_next = S_RESP;
         S_RESP:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Q is held from accept to the next accept so the multiplier sees a stable multiplicand.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q        <= '0;
         r_shreg    <= '0;
         r_bit_cnt  <= '0;
         r_wait_cnt <= '0;
         r_prod     <= '0;
      end else begin
         if (w_accept) begin
            r_q     <= q_in;
            r_shreg <= m_in;
         end
         if (r_state == S_CLR) begin
            r_bit_cnt <= '0;
         end
         if (r_state == S_SHIFT) begin
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= r_bit_cnt + CW'(1);
            if (w_shift_last) begin
               r_wait_cnt <= '0;
            end
         end
         if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
            if (w_wait_last) begin
               r_prod <= mul_prod;
            end
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign mul_clr   = (r_state == S_CLR);
   assign mul_frame = (r_state == S_SHIFT);
   assign mul_bit   = (r_state == S_SHIFT) && r_shreg[0];
   assign out_valid = (r_state == S_RESP);
   assign mul_q     = r_q;
   assign out_prod  = r_prod;

endmodule

// File: tb/tb_seq_mul_feeder.sv
// Bench for seq_mul_feeder: a behavioural serial multiplier drives mul_prod, and
// results are checked against Q*M and the documented cycle timing.
module tb_seq_mul_feeder;

   localparam int W = 8;
   localparam int L = 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     q_in;
   logic [W-1:0]     m_in;
   logic [W-1:0]     mul_q;
   logic             mul_clr;
   logic             mul_frame;
   logic             mul_bit;
   logic [2*W-1:0]   mul_prod;
   logic             out_valid;
   logic             out_ready;
   logic [2*W-1:0]   out_prod;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_mul_feeder #(.WIDTH(W), .LAT(L)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .q_in(q_in), .m_in(m_in),
      .mul_q(mul_q), .mul_clr(mul_clr), .mul_frame(mul_frame), .mul_bit(mul_bit),
      .mul_prod(mul_prod),
      .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod)
   );

   // Serial multiplier stand-in: product is only valid in the one clock after the
   // last framed bit; otherwise mul_prod carries junk so a mistimed capture shows up.
   logic [2*W-1:0] acc;
   logic [2*W-1:0] junk;
   logic [7:0]     idx;
   logic           mv;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         acc  <= '0;
         junk <= '0;
         idx  <= '0;
         mv   <= 1'b0;
      end else begin
         junk <= (2*W)'($urandom);
         mv   <= mul_frame && (idx == 8'(W - 1));
         if (mul_clr) begin
            acc <= '0;
            idx <= '0;
         end else if (mul_frame) begin
            if (mul_bit) acc <= acc + ({{W{1'b0}}, mul_q} << idx);
            idx <= idx + 8'd1;
         end
      end
   end

   assign mul_prod = mv ? acc : junk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at a negedge while the feeder is in IDLE; returns at the negedge of the
   // IDLE clock following the result handshake.
   task automatic txn(input logic [W-1:0] q, input logic [W-1:0] m,
                      input logic [31:0] exp_prod, input int bp, input logic keep_valid);
      int  cyc;
      bit  seen;
      out_ready = (bp == 0);
      q_in      = q;
      m_in      = m;
      in_valid  = 1'b1;
      chk1("accept_in_ready", in_ready, 1'b1);
      @(negedge clk);
      if (!keep_valid) in_valid = 1'b0;
      chk1("clr_pulse", mul_clr, 1'b1);
      chk1("clr_frame", mul_frame, 1'b0);
      chk1("busy_in_ready", in_ready, 1'b0);
      chk("mul_q", 32'(mul_q), 32'(q));
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk1("bit_frame", mul_frame, 1'b1);
         chk1("bit_value", mul_bit, m[i]);
         chk1("bit_clr", mul_clr, 1'b0);
      end
      cyc  = W + 1;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         cyc++;
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         chk1("wait_frame", mul_frame, 1'b0);
         chk1("wait_bit", mul_bit, 1'b0);
      end
      chk1("out_valid_seen", seen, 1'b1);
      chk("out_valid_cycle", cyc, W + L + 2);
      chk("out_prod", 32'(out_prod), exp_prod);
      chk1("resp_in_ready", in_ready, 1'b0);
      for (int b = 0; b < bp; b++) begin
         @(negedge clk);
         if (b == 0) begin
            in_valid = 1'b1;
            q_in     = q ^ 8'hA5;
         end
         chk1("bp_out_valid", out_valid, 1'b1);
         chk("bp_out_prod", 32'(out_prod), exp_prod);
         chk1("bp_in_ready", in_ready, 1'b0);
         chk1("bp_no_clr", mul_clr, 1'b0);
         chk("bp_mul_q", 32'(mul_q), 32'(q));
      end
      if (bp > 0) begin
         in_valid  = keep_valid;
         q_in      = q;
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk1("post_hs_out_valid", out_valid, 1'b0);
      chk1("post_hs_in_ready", in_ready, 1'b1);
      chk("post_hs_out_prod", 32'(out_prod), exp_prod);
   endtask

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] m;
      logic [31:0]  prod;
      int           bp;
   } vec_t;

   vec_t vt[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, failed %0d", fails);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{q: 8'd20,  m: 8'd10,  prod: 32'd200,   bp: 0};
      vt[1] = '{q: 8'd255, m: 8'd255, prod: 32'd65025, bp: 0};
      vt[2] = '{q: 8'd7,   m: 8'd0,   prod: 32'd0,     bp: 0};
      vt[3] = '{q: 8'd0,   m: 8'd255, prod: 32'd0,     bp: 1};
      vt[4] = '{q: 8'd1,   m: 8'd128, prod: 32'd128,   bp: 0};
      vt[5] = '{q: 8'd128, m: 8'd2,   prod: 32'd256,   bp: 2};
      vt[6] = '{q: 8'd20,  m: 8'd10,  prod: 32'd200,   bp: 5};

      reset     = 1'b1;
      in_valid  = 1'b0;
      q_in      = '0;
      m_in      = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_mul_clr", mul_clr, 1'b0);
      chk1("rst_mul_frame", mul_frame, 1'b0);
      chk1("rst_mul_bit", mul_bit, 1'b0);
      chk("rst_mul_q", 32'(mul_q), 32'd0);
      chk("rst_out_prod", 32'(out_prod), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk1("idle_in_ready", in_ready, 1'b1);

      foreach (vt[i]) txn(vt[i].q, vt[i].m, vt[i].prod, vt[i].bp, 1'b0);

      // Reset mid-SHIFT: outputs must fall back immediately, no partial result.
      out_ready = 1'b1;
      q_in      = 8'd9;
      m_in      = 8'hFF;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      chk1("pre_rst_frame", mul_frame, 1'b1);
      reset = 1'b1;
      #1;
      chk1("mid_rst_frame", mul_frame, 1'b0);
      chk1("mid_rst_bit", mul_bit, 1'b0);
      chk1("mid_rst_out_valid", out_valid, 1'b0);
      chk1("mid_rst_clr", mul_clr, 1'b0);
      chk("mid_rst_mul_q", 32'(mul_q), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk1("after_rst_in_ready", in_ready, 1'b1);
      chk("after_rst_out_prod", 32'(out_prod), 32'd0);
      txn(8'd3, 8'd5, 32'd15, 0, 1'b0);

      // Back-to-back with in_valid held: second pair accepted the clock after the handshake.
      txn(8'd20, 8'd10, 32'd200, 0, 1'b1);
      txn(8'd12, 8'd12, 32'd144, 0, 1'b0);

      for (int r = 0; r < 20; r++) begin
         logic [W-1:0] rq;
         logic [W-1:0] rm;
         logic [31:0]  e;
         rq = W'($urandom_range(0, 255));
         rm = W'($urandom_range(0, 255));
         e  = 32'(rq) * 32'(rm);
         txn(rq, rm, e, $urandom_range(0, 2), 1'(r % 3 == 0));
         in_valid = 1'b0;
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
